// File: rtl/mseq_pkg.sv
// rtl/mseq_pkg.sv - micro-word layout, opcodes, branch conditions and control-store map for the micro sequencer
package mseq_pkg;

    localparam int IW      = 22;
    localparam int MIW     = 33;
    localparam int UADDR_W = 5;
    localparam int RF_W    = 5;
    localparam int OP_W    = 4;
    localparam int RSV_W   = IW - OP_W - 11;

    // Datapath micro-word: {ALU4, SH2, KMX, MR, MW, BUS_B6, BUS_C6, T_WORD7, BUS_A5}
    localparam int BUS_A_LSB = 0;
    localparam int BUS_A_W   = 5;
    localparam int T_LSB     = 5;
    localparam int T_W       = 7;
    localparam int BUS_C_LSB = 12;
    localparam int BUS_C_W   = 6;
    localparam int BUS_B_LSB = 18;
    localparam int BUS_B_W   = 6;
    localparam int MW_BIT    = 24;
    localparam int MR_BIT    = 25;
    localparam int KMX_BIT   = 26;
    localparam int SH_LSB    = 27;
    localparam int SH_W      = 2;
    localparam int ALU_LSB   = 29;
    localparam int ALU_W     = 4;

    // Opcodes 1xxx are the branch family, decoded on opcode[3:1]
    localparam logic [OP_W-1:0] OP_MOV    = 4'b0010;
    localparam logic [OP_W-1:0] OP_MOM_YW = 4'b0100;
    localparam logic [OP_W-1:0] OP_MOM_WY = 4'b0101;
    localparam logic [OP_W-1:0] OP_ADW    = 4'b0110;
    localparam logic [OP_W-1:0] OP_BSR    = 4'b0111;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_Z      = 2'b01,
        COND_NZ     = 2'b10,
        COND_CY     = 2'b11
    } cond_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // Each conditional routine is word0, fall-through NOP at word0+1, load-PC target at word0+2
    localparam logic [UADDR_W-1:0] UA_JUMP    = 5'd0;
    localparam logic [UADDR_W-1:0] UA_JZE     = 5'd1;
    localparam logic [UADDR_W-1:0] UA_JZE_NOP = 5'd2;
    localparam logic [UADDR_W-1:0] UA_JZE_PC  = 5'd3;
    localparam logic [UADDR_W-1:0] UA_JNE     = 5'd4;
    localparam logic [UADDR_W-1:0] UA_JNE_NOP = 5'd5;
    localparam logic [UADDR_W-1:0] UA_JNE_PC  = 5'd6;
    localparam logic [UADDR_W-1:0] UA_JCY     = 5'd7;
    localparam logic [UADDR_W-1:0] UA_JCY_NOP = 5'd8;
    localparam logic [UADDR_W-1:0] UA_JCY_PC  = 5'd9;
    localparam logic [UADDR_W-1:0] UA_MOM_YW  = 5'd10;
    localparam logic [UADDR_W-1:0] UA_MOM_WY  = 5'd11;
    localparam logic [UADDR_W-1:0] UA_ADW     = 5'd12;
    localparam logic [UADDR_W-1:0] UA_MOV     = 5'd13;
    localparam logic [UADDR_W-1:0] UA_BSR     = 5'd14;

    localparam logic [BUS_B_W-1:0] BUS_B_DEF = 6'b100010;
    localparam logic [BUS_C_W-1:0] BUS_C_DEF = 6'b100011;

    localparam logic [T_W-1:0] T_NOP     = 7'b0000000;
    localparam logic [T_W-1:0] T_LOAD_PC = 7'b1000000;
    localparam logic [T_W-1:0] T_MOM_YW  = 7'b0000001;
    localparam logic [T_W-1:0] T_MOM_WY  = 7'b0000010;
    localparam logic [T_W-1:0] T_ADW     = 7'b0111101;
    localparam logic [T_W-1:0] T_MOV     = 7'b0001100;

    localparam logic [ALU_W-1:0] ALU_NONE = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0101;

    typedef struct packed {
        logic [MIW-1:0]     dp;
        logic               sel_c;
        logic               sel_a;
        logic               last;
        cond_e              cond;
        logic [UADDR_W-1:0] next;
    } cs_word_t;

    function automatic logic [MIW-1:0] dp_word(
        input logic [ALU_W-1:0] alu,
        input logic             mr,
        input logic             mw,
        input logic [T_W-1:0]   t_word
    );
        dp_word = {alu, 2'b00, 1'b0, mr, mw, BUS_B_DEF, BUS_C_DEF, t_word, 5'b00000};
    endfunction

    function automatic cs_word_t cs_word(
        input logic [MIW-1:0]     dp,
        input logic               sel_c,
        input logic               sel_a,
        input logic               last,
        input cond_e              cond,
        input logic [UADDR_W-1:0] next
    );
        cs_word.dp    = dp;
        cs_word.sel_c = sel_c;
        cs_word.sel_a = sel_a;
        cs_word.last  = last;
        cs_word.cond  = cond;
        cs_word.next  = next;
    endfunction

endpackage

// File: rtl/micro_store.sv
// rtl/micro_store.sv - combinational control-store ROM and opcode dispatch table
module micro_store
    import mseq_pkg::*;
(
    input  logic [UADDR_W-1:0] addr,
    input  logic [OP_W-1:0]    opcode,
    output cs_word_t           word,
    output logic [UADDR_W-1:0] start_addr,
    output logic               legal
);

    always_comb begin
        // Unused addresses and fall-through slots decode as a NOP that ends the routine
        word = cs_word(dp_word(ALU_NONE, 1'b0, 1'b0, T_NOP), 1'b0, 1'b0, 1'b1, COND_ALWAYS, addr);
        case (addr)
            UA_JUMP, UA_JZE_PC, UA_JNE_PC, UA_JCY_PC, UA_BSR:
                word = cs_word(dp_word(ALU_NONE, 1'b0, 1'b0, T_LOAD_PC), 1'b0, 1'b0, 1'b1, COND_ALWAYS, addr);
            UA_JZE:
                word = cs_word(dp_word(ALU_NONE, 1'b0, 1'b0, T_NOP), 1'b0, 1'b0, 1'b0, COND_Z, UA_JZE_PC);
            UA_JNE:
                word = cs_word(dp_word(ALU_NONE, 1'b0, 1'b0, T_NOP), 1'b0, 1'b0, 1'b0, COND_NZ, UA_JNE_PC);
            UA_JCY:
                word = cs_word(dp_word(ALU_NONE, 1'b0, 1'b0, T_NOP), 1'b0, 1'b0, 1'b0, COND_CY, UA_JCY_PC);
            UA_MOM_YW:
                word = cs_word(dp_word(ALU_NONE, 1'b0, 1'b1, T_MOM_YW), 1'b0, 1'b0, 1'b1, COND_ALWAYS, addr);
            UA_MOM_WY:
                word = cs_word(dp_word(ALU_NONE, 1'b1, 1'b0, T_MOM_WY), 1'b0, 1'b0, 1'b1, COND_ALWAYS, addr);
            UA_ADW:
                word = cs_word(dp_word(ALU_ADD, 1'b0, 1'b0, T_ADW), 1'b1, 1'b1, 1'b1, COND_ALWAYS, addr);
            UA_MOV:
                word = cs_word(dp_word(ALU_NONE, 1'b0, 1'b0, T_MOV), 1'b1, 1'b1, 1'b1, COND_ALWAYS, addr);
            default: ;
        endcase
    end

    always_comb begin
        start_addr = UA_JUMP;
        legal      = 1'b1;
        casez (opcode)
            4'b100?:   start_addr = UA_JUMP;
            4'b101?:   start_addr = UA_JZE;
            4'b110?:   start_addr = UA_JNE;
            4'b111?:   start_addr = UA_JCY;
            OP_MOM_YW: start_addr = UA_MOM_YW;
            OP_MOM_WY: start_addr = UA_MOM_WY;
            OP_ADW:    start_addr = UA_ADW;
            OP_BSR:    start_addr = UA_BSR;
            OP_MOV:    start_addr = UA_MOV;
            default:   legal      = 1'b0;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// rtl/micro_sequencer.sv - microprogrammed control unit stepping control-store routines per macro-instruction
module micro_sequencer
    import mseq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [IW-1:0]  instruction,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic           zf,
    input  logic           cf,
    input  logic           dp_stall,
    output logic [MIW-1:0] micro_instruction,
    output logic           mi_valid,
    output logic           mi_last,
    output logic           illegal_op
);

    state_e               state;
    state_e               state_nxt;
    logic [UADDR_W-1:0]   upc;
    logic [2*RF_W-1:0]    ir_regs;
    cond_e                cur_cond;
    logic [UADDR_W-1:0]   cur_next;

    logic                 accept;
    logic                 bad_in;
    logic                 load_new;
    logic                 advance;
    logic                 finish;
    logic                 taken;
    logic                 legal;
    logic [UADDR_W-1:0]   start_addr;
    logic [UADDR_W-1:0]   rd_addr;
    logic [2*RF_W-1:0]    src_regs;
    cs_word_t             word;
    logic [MIW-1:0]       dp_next;
    logic                 unused_operand_bit;

    assign unused_operand_bit = instruction[10];

    assign finish      = (state == ST_EXEC) && mi_last && !dp_stall;
    assign advance     = (state == ST_EXEC) && !mi_last && !dp_stall;
    assign instr_ready = (state == ST_IDLE) || finish;
    assign accept      = instr_valid && instr_ready;
    assign bad_in      = !legal || (instruction[IW-OP_W-1 -: RSV_W] != '0);
    assign load_new    = accept && !bad_in;

    // Branch conditions are evaluated against the word currently on the outputs
    always_comb begin
        taken = 1'b0;
        case (cur_cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = zf;
            COND_NZ:     taken = !zf;
            COND_CY:     taken = cf;
            default:     taken = 1'b0;
        endcase
    end

    always_comb begin
        if (load_new) begin
            rd_addr  = start_addr;
            src_regs = instruction[2*RF_W-1:0];
        end else begin
            rd_addr  = taken ? cur_next : upc + UADDR_W'(1);
            src_regs = ir_regs;
        end
    end

    micro_store u_store (
        .addr       (rd_addr),
        .opcode     (instruction[IW-1 -: OP_W]),
        .word       (word),
        .start_addr (start_addr),
        .legal      (legal)
    );

    // Register-field substitution takes Ri/Rj from the instruction that owns the word
    always_comb begin
        dp_next = word.dp;
        if (word.sel_c) begin
            dp_next[BUS_C_LSB +: BUS_C_W] = BUS_C_W'(src_regs[2*RF_W-1:RF_W]);
        end
        if (word.sel_a) begin
            dp_next[BUS_A_LSB +: BUS_A_W] = src_regs[RF_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (load_new) state_nxt = ST_EXEC;
            ST_EXEC: if (finish)   state_nxt = load_new ? ST_EXEC : ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc               <= '0;
            ir_regs           <= '0;
            cur_cond          <= COND_ALWAYS;
            cur_next          <= '0;
            micro_instruction <= '0;
            mi_valid          <= 1'b0;
            mi_last           <= 1'b0;
            illegal_op        <= 1'b0;
        end else begin
            illegal_op <= accept && bad_in;
            if (load_new || advance) begin
                upc               <= rd_addr;
                cur_cond          <= word.cond;
                cur_next          <= word.next;
                micro_instruction <= dp_next;
                mi_valid          <= 1'b1;
                mi_last           <= word.last;
                if (load_new) begin
                    ir_regs <= instruction[2*RF_W-1:0];
                end
            end else if (finish) begin
                micro_instruction <= '0;
                mi_valid          <= 1'b0;
                mi_last           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// tb/tb_micro_sequencer.sv - directed self-checking bench for micro_sequencer
module tb_micro_sequencer;

    logic        clk;
    logic        rst;
    logic [21:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        zf;
    logic        cf;
    logic        dp_stall;
    logic [32:0] micro_instruction;
    logic        mi_valid;
    logic        mi_last;
    logic        illegal_op;

    int n_cmp;
    int n_bad;

    // {ALU4, SH2, KMX, MR, MW, BUS_B6, BUS_C6, T_WORD7, BUS_A5}
    localparam logic [32:0] W_NOP = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b100011, 7'b0000000, 5'b00000};
    localparam logic [32:0] W_PC  = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b100011, 7'b1000000, 5'b00000};
    localparam logic [32:0] W_MR  = {4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 6'b100010, 6'b100011, 7'b0000010, 5'b00000};
    localparam logic [32:0] W_MW  = {4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 6'b100010, 6'b100011, 7'b0000001, 5'b00000};
    localparam logic [32:0] W_ADW = {4'b0101, 2'b00, 1'b0, 1'b0, 1'b0, 6'b100010, 6'b000011, 7'b0111101, 5'b00100};

    micro_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .instruction       (instruction),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .zf                (zf),
        .cf                (cf),
        .dp_stall          (dp_stall),
        .micro_instruction (micro_instruction),
        .mi_valid          (mi_valid),
        .mi_last           (mi_last),
        .illegal_op        (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        instruction = '0;
        instr_valid = 1'b0;
        zf          = 1'b0;
        cf          = 1'b0;
        dp_stall    = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mi", micro_instruction, 0);
        check("rst_valid", mi_valid, 0);
        check("rst_last", mi_last, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_ready", instr_ready, 1);
        rst = 1'b0;

        // ADW Ri=3 Rj=4
        @(negedge clk);
        instruction = 22'h180064;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("adw_valid", mi_valid, 1);
        check("adw_last", mi_last, 1);
        check("adw_alu", micro_instruction[32:29], 4'b0101);
        check("adw_busc", micro_instruction[17:12], 6'b000011);
        check("adw_tword", micro_instruction[11:5], 7'b0111101);
        check("adw_busa", micro_instruction[4:0], 5'b00100);
        check("adw_word", micro_instruction, W_ADW);
        @(negedge clk);
        check("adw_idle_valid", mi_valid, 0);
        check("adw_idle_mi", micro_instruction, 0);

        // JZE, zf=1 -> load-PC word
        instruction = 22'h280000;
        instr_valid = 1'b1;
        zf          = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("jze1_w0", micro_instruction, W_NOP);
        check("jze1_w0_last", mi_last, 0);
        check("jze1_w0_valid", mi_valid, 1);
        @(negedge clk);
        check("jze1_w1", micro_instruction, W_PC);
        check("jze1_w1_last", mi_last, 1);
        @(negedge clk);
        check("jze1_idle", mi_valid, 0);

        // JZE, zf=0 -> NOP END
        instruction = 22'h280000;
        instr_valid = 1'b1;
        zf          = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        check("jze0_w0", micro_instruction, W_NOP);
        check("jze0_w0_last", mi_last, 0);
        @(negedge clk);
        check("jze0_w1", micro_instruction, W_NOP);
        check("jze0_w1_last", mi_last, 1);
        check("jze0_w1_valid", mi_valid, 1);
        @(negedge clk);

        // Back-to-back MOM W,Y then MOM Y,W
        instruction = 22'h140000;
        instr_valid = 1'b1;
        @(negedge clk);
        check("b2b_mr", micro_instruction, W_MR);
        check("b2b_mr_last", mi_last, 1);
        check("b2b_ready", instr_ready, 1);
        instruction = 22'h100000;
        @(negedge clk);
        instr_valid = 1'b0;
        check("b2b_mw", micro_instruction, W_MW);
        check("b2b_mw_valid", mi_valid, 1);
        check("b2b_mw_last", mi_last, 1);
        @(negedge clk);
        check("b2b_idle", mi_valid, 0);

        // JCY with a 3-cycle stall on word0 while cf toggles
        instruction = 22'h380000;
        instr_valid = 1'b1;
        cf          = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        check("jcy_w0", micro_instruction, W_NOP);
        dp_stall = 1'b1;
        cf       = 1'b1;
        @(negedge clk);
        check("jcy_stall1_mi", micro_instruction, W_NOP);
        check("jcy_stall1_last", mi_last, 0);
        check("jcy_stall1_ready", instr_ready, 0);
        cf = 1'b0;
        @(negedge clk);
        check("jcy_stall2_mi", micro_instruction, W_NOP);
        check("jcy_stall2_valid", mi_valid, 1);
        cf = 1'b1;
        @(negedge clk);
        check("jcy_stall3_mi", micro_instruction, W_NOP);
        check("jcy_stall3_last", mi_last, 0);
        dp_stall = 1'b0;
        cf       = 1'b0;
        @(negedge clk);
        check("jcy_unstall_mi", micro_instruction, W_NOP);
        check("jcy_unstall_last", mi_last, 1);
        @(negedge clk);

        // Illegal opcode 0000
        instruction = 22'h000000;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("ill_op_pulse", illegal_op, 1);
        check("ill_op_valid", mi_valid, 0);
        check("ill_op_ready", instr_ready, 1);
        @(negedge clk);
        check("ill_op_pulse_end", illegal_op, 0);

        // ADW with reserved bit 12 set
        instruction = 22'h181000;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("ill_rsv_pulse", illegal_op, 1);
        check("ill_rsv_valid", mi_valid, 0);
        check("ill_rsv_mi", micro_instruction, 0);
        check("ill_rsv_ready", instr_ready, 1);
        @(negedge clk);
        check("ill_rsv_pulse_end", illegal_op, 0);

        // JNE with zf=0, reset asserted during its second word
        instruction = 22'h300000;
        instr_valid = 1'b1;
        zf          = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        check("jne_w0", micro_instruction, W_NOP);
        @(negedge clk);
        check("jne_w1", micro_instruction, W_PC);
        check("jne_w1_valid", mi_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_mi", micro_instruction, 0);
        check("async_rst_valid", mi_valid, 0);
        check("async_rst_last", mi_last, 0);
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_ready", instr_ready, 1);
        @(negedge clk);
        check("post_rst_idle", mi_valid, 0);

        // JUMP after reset release
        instruction = 22'h200000;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("jump_word", micro_instruction, W_PC);
        check("jump_last", mi_last, 1);
        @(negedge clk);
        check("jump_idle", mi_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
